l2cache_dirty_flush_ctrl: RTL and testbench

Owns the ports of the L2 dirty table and shares them between two users: the normal L2 pipeline and a flush sequencer. On a flush request it walks every (set, way) entry, reads its dirty bit, and issues a writeback request for each dirty line. After each accepted writeback it clears that dirty bit, then reports completion. It sits between the L2 main pipeline, the dirty table, and the L2 writeback/memory-side unit.

---
 rtl/l2cache_dirty_flush_ctrl_if.sv | 12 +
 rtl/l2cache_dirty_flush_ctrl.sv | 129 ++++++++++++
 tb/tb_l2cache_dirty_flush_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2cache_dirty_flush_ctrl_if.sv
// Writeback request channel from the flush walker to the L2 writeback unit.
interface l2cache_dirty_flush_ctrl_if #(
  parameter int addr_width = 4
);
  logic                  wb_valid;
  logic                  wb_ready;
  logic [addr_width-1:0] wb_set;
  logic [2:0]            wb_way;

  modport master (output wb_valid, output wb_set, output wb_way, input wb_ready);
  modport slave  (input wb_valid, input wb_set, input wb_way, output wb_ready);
endinterface

// File: rtl/l2cache_dirty_flush_ctrl.sv
// Arbitrates the L2 dirty table between the pipeline and a flush walker that writes back dirty lines.
// Define L2_FLUSH_WBCNT_EN to add the flush_wb_cnt writeback counter output.
module l2cache_dirty_flush_ctrl #(
  parameter int addr_width = 4,
  parameter int way        = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [addr_width-1:0] pipe_addr,
  input  logic [addr_width-1:0] pipe_addrw,
  input  logic [2:0]            pipe_way,
  input  logic                  pipe_set1,
  input  logic                  pipe_set0,
  output logic                  pipe_grant,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  flush_done,
  output logic [addr_width-1:0] dt_addr,
  output logic [addr_width-1:0] dt_addrw,
  output logic [2:0]            dt_way,
  output logic                  dt_set1,
  output logic                  dt_set0,
  input  logic                  dt_dirty,
  l2cache_dirty_flush_ctrl_if.master wb
`ifdef L2_FLUSH_WBCNT_EN
  ,
  output logic [addr_width+3:0] flush_wb_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, RD, CHK, WB, CLR, DONE} state_t;

  localparam logic [2:0]            LAST_WAY = 3'(way - 1);
  localparam logic [addr_width-1:0] LAST_SET = '1;
  localparam logic [addr_width-1:0] SET_ONE  = addr_width'(1);

  state_t                state, state_nxt;
  logic [addr_width-1:0] set_q, set_nxt;
  logic [2:0]            way_q, way_nxt;
  logic                  step;
  logic                  last_entry;
  logic                  wb_fire;

  assign last_entry = (set_q == LAST_SET) && (way_q == LAST_WAY);
  assign wb_fire    = wb.wb_valid && wb.wb_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      set_q <= '0;
      way_q <= '0;
    end else begin
      state <= state_nxt;
      set_q <= set_nxt;
      way_q <= way_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    set_nxt   = set_q;
    way_nxt   = way_q;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (flush_req) begin
          state_nxt = RD;
          set_nxt   = '0;
          way_nxt   = '0;
        end
      end
      RD:      state_nxt = CHK;
      CHK:     if (dt_dirty) state_nxt = WB; else step = 1'b1;
      WB:      if (wb.wb_ready) state_nxt = CLR;
      CLR:     step = 1'b1;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Walk order: way is the fast index, set the slow one.
    if (step) begin
      if (last_entry) begin
        state_nxt = DONE;
      end else begin
        state_nxt = RD;
        if (way_q == LAST_WAY) begin
          way_nxt = '0;
          set_nxt = set_q + SET_ONE;
        end else begin
          way_nxt = way_q + 3'd1;
        end
      end
    end
  end

  always_comb begin
    pipe_grant  = (state == IDLE);
    flush_busy  = (state != IDLE);
    flush_done  = (state == DONE);
    wb.wb_valid = (state == WB);
    wb.wb_set   = set_q;
    wb.wb_way   = way_q;
    if (pipe_grant) begin
      dt_addr  = pipe_addr;
      dt_addrw = pipe_addrw;
      dt_way   = pipe_way;
      dt_set1  = pipe_set1;
      dt_set0  = pipe_set0;
    end else begin
      dt_addr  = set_q;
      dt_addrw = set_q;
      dt_way   = way_q;
      dt_set1  = 1'b0;
      dt_set0  = (state == CLR);
    end
  end

`ifdef L2_FLUSH_WBCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_wb_cnt <= '0;
    end else if ((state == IDLE) && flush_req) begin
      flush_wb_cnt <= '0;
    end else if (wb_fire) begin
      flush_wb_cnt <= flush_wb_cnt + (addr_width+4)'(1);
    end
  end
`endif

endmodule

// File: tb/tb_l2cache_dirty_flush_ctrl.sv
// Scoreboard bench: main DUT (8 ways) with random dirty patterns and writeback stalls, plus a 4-way instance.
`timescale 1ns/1ps
module tb_l2cache_dirty_flush_ctrl;
  localparam int AW  = 4;
  localparam int NS  = 1 << AW;
  localparam int NW  = 8;
  localparam int NW4 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] pipe_addr, pipe_addrw;
  logic [2:0]    pipe_way;
  logic          pipe_set1, pipe_set0, flush_req, flush_req4;
  logic          pipe_grant, flush_busy, flush_done;
  logic [AW-1:0] dt_addr, dt_addrw;
  logic [2:0]    dt_way;
  logic          dt_set1, dt_set0, dt_dirty;
  logic          pipe_grant4, flush_busy4, flush_done4;
  logic [AW-1:0] dt_addr4, dt_addrw4;
  logic [2:0]    dt_way4;
  logic          dt_set14, dt_set04, dt_dirty4;
`ifdef L2_FLUSH_WBCNT_EN
  logic [AW+3:0] flush_wb_cnt, flush_wb_cnt4;
`endif

  l2cache_dirty_flush_ctrl_if #(.addr_width(AW)) wb ();
  l2cache_dirty_flush_ctrl_if #(.addr_width(AW)) wb4 ();

  l2cache_dirty_flush_ctrl #(.addr_width(AW), .way(NW)) dut (
    .clk(clk), .rst(rst), .pipe_addr(pipe_addr), .pipe_addrw(pipe_addrw), .pipe_way(pipe_way),
    .pipe_set1(pipe_set1), .pipe_set0(pipe_set0), .pipe_grant(pipe_grant), .flush_req(flush_req),
    .flush_busy(flush_busy), .flush_done(flush_done), .dt_addr(dt_addr), .dt_addrw(dt_addrw),
    .dt_way(dt_way), .dt_set1(dt_set1), .dt_set0(dt_set0), .dt_dirty(dt_dirty), .wb(wb)
`ifdef L2_FLUSH_WBCNT_EN
    , .flush_wb_cnt(flush_wb_cnt)
`endif
  );

  l2cache_dirty_flush_ctrl #(.addr_width(AW), .way(NW4)) dut4 (
    .clk(clk), .rst(rst), .pipe_addr(pipe_addr), .pipe_addrw(pipe_addrw), .pipe_way(pipe_way),
    .pipe_set1(pipe_set1), .pipe_set0(pipe_set0), .pipe_grant(pipe_grant4), .flush_req(flush_req4),
    .flush_busy(flush_busy4), .flush_done(flush_done4), .dt_addr(dt_addr4), .dt_addrw(dt_addrw4),
    .dt_way(dt_way4), .dt_set1(dt_set14), .dt_set0(dt_set04), .dt_dirty(dt_dirty4), .wb(wb4)
`ifdef L2_FLUSH_WBCNT_EN
    , .flush_wb_cnt(flush_wb_cnt4)
`endif
  );

  // Dirty table models: registered read, set/clear strobes on the write index.
  logic tbl  [NS][8];
  logic tbl4 [NS][8];
  logic tbl_clr;
  always @(posedge clk) begin
    if (tbl_clr) begin
      for (int s = 0; s < NS; s++)
        for (int w = 0; w < 8; w++) begin
          tbl[s][w]  <= 1'b0;
          tbl4[s][w] <= 1'b0;
        end
    end else begin
      dt_dirty  <= tbl[dt_addr][dt_way];
      dt_dirty4 <= tbl4[dt_addr4][dt_way4];
      if (dt_set1)  tbl[dt_addrw][dt_way]    <= 1'b1;
      if (dt_set0)  tbl[dt_addrw][dt_way]    <= 1'b0;
      if (dt_set14) tbl4[dt_addrw4][dt_way4] <= 1'b1;
      if (dt_set04) tbl4[dt_addrw4][dt_way4] <= 1'b0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writeback acceptance: forced level or random with ~25% stall rate.
  logic ready_force = 1'b1;
  logic ready_val   = 1'b1;
  initial begin
    wb.wb_ready  = 1'b1;
    wb4.wb_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      wb.wb_ready = ready_force ? ready_val : ($urandom_range(0, 3) != 0);
    end
  end

  typedef struct {
    int s;
    int w;
  } ent_t;

  ent_t exp_q[$];
  int   busy_cyc = 0, wait_cyc = 0, exp_dirty = 0, hs_cnt = 0, done_cnt = 0;
  bit   in_flush = 0, pend_clr = 0, prev_stall = 0;
  int   pc_s, pc_w, ps_s, ps_w;

  // Main monitor: reference expectations are built from a table snapshot at flush start.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        in_flush = 0; pend_clr = 0; prev_stall = 0;
        busy_cyc = 0; wait_cyc = 0; hs_cnt = 0;
        continue;
      end
      chk("busy", flush_busy, in_flush);
      chk("grant", pipe_grant, !in_flush);
      if (pend_clr) begin
        chk("clr_strobe", dt_set0, 1);
        chk("clr_set", dt_addrw, pc_s);
        chk("clr_way", dt_way, pc_w);
        pend_clr = 0;
      end else if (!pipe_grant) begin
        chk("no_stray_clr", dt_set0, 0);
      end
      if (!pipe_grant) chk("no_set1_in_flush", dt_set1, 0);
      if (prev_stall) begin
        chk("wb_hold_valid", wb.wb_valid, 1);
        chk("wb_hold_set", wb.wb_set, ps_s);
        chk("wb_hold_way", wb.wb_way, ps_w);
      end
      prev_stall = wb.wb_valid && !wb.wb_ready;
      ps_s = int'(wb.wb_set);
      ps_w = int'(wb.wb_way);
      if (wb.wb_valid && !wb.wb_ready) wait_cyc++;
      if (wb.wb_valid && wb.wb_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          chk("wb_unexpected_handshake", 1, 0);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("wb_set", wb.wb_set, e.s);
          chk("wb_way", wb.wb_way, e.w);
        end
        pend_clr = 1;
        pc_s = int'(wb.wb_set);
        pc_w = int'(wb.wb_way);
      end
      if (flush_busy && !flush_done) busy_cyc++;
      if (flush_done) begin
        chk("done_in_flush", in_flush, 1);
        // clean entry = 2 cycles; dirty adds WB and CLR plus stall cycles
        chk("done_cycles", busy_cyc, 2 * NS * NW + 2 * exp_dirty + wait_cyc);
        chk("done_queue_empty", exp_q.size(), 0);
`ifdef L2_FLUSH_WBCNT_EN
        chk("wb_cnt", flush_wb_cnt, hs_cnt);
`endif
        done_cnt++;
        in_flush = 0;
      end
      if (pipe_grant && flush_req) begin
        exp_dirty = 0; busy_cyc = 0; wait_cyc = 0; hs_cnt = 0;
        exp_q.delete();
        for (int s = 0; s < NS; s++)
          for (int w = 0; w < NW; w++) begin
            bit d;
            d = tbl[s][w];
            if (pipe_set1 && int'(pipe_addrw) == s && int'(pipe_way) == w) d = 1;
            if (pipe_set0 && int'(pipe_addrw) == s && int'(pipe_way) == w) d = 0;
            if (d) begin
              exp_q.push_back('{s: s, w: w});
              exp_dirty++;
            end
          end
        in_flush = 1;
      end
    end
  end

  int k4 = 0, done4_cnt = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wb4.wb_valid && wb4.wb_ready) begin
          chk("w4_set", wb4.wb_set, k4 / NW4);
          chk("w4_way", wb4.wb_way, k4 % NW4);
          k4++;
        end
        if (flush_done4) done4_cnt++;
      end
    end
  end

  task automatic pwrite(input int s, input int w, input bit v);
    pipe_addrw = AW'(s);
    pipe_way   = 3'(w);
    pipe_set1  = v;
    pipe_set0  = !v;
    tick();
    pipe_set1 = 1'b0;
    pipe_set0 = 1'b0;
  endtask

  task automatic pread(input string name, input int s, input int w, input bit exp);
    pipe_addr = AW'(s);
    pipe_way  = 3'(w);
    tick();
    chk(name, dt_dirty, exp);
  endtask

  task automatic start_flush();
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = done_cnt;
    for (int i = 0; i < budget && done_cnt == start; i++) tick();
    chk("flush_done_seen", done_cnt - start, 1);
  endtask

  task automatic wait_wb_valid(input int budget);
    for (int i = 0; i < budget && !wb.wb_valid; i++) tick();
    chk("wb_valid_seen", wb.wb_valid, 1);
  endtask

  task automatic check_clean(input string name);
    int n;
    n = 0;
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) n += int'(tbl[s][w]);
    chk(name, n, 0);
  endtask

  initial begin
    rst = 1'b1; tbl_clr = 1'b1;
    pipe_addr = '0; pipe_addrw = '0; pipe_way = '0;
    pipe_set1 = 1'b0; pipe_set0 = 1'b0; flush_req = 1'b0; flush_req4 = 1'b0;
    repeat (3) tick();
    rst = 1'b0; tbl_clr = 1'b0;
    chk("rst_grant", pipe_grant, 1);
    chk("rst_busy", flush_busy, 0);
    chk("rst_done", flush_done, 0);
    chk("rst_wb_valid", wb.wb_valid, 0);
    chk("rst_set1", dt_set1, 0);
    chk("rst_set0", dt_set0, 0);

    // All clean: 256-cycle walk, no writebacks.
    start_flush();
    chk("flush_grant_low", pipe_grant, 0);
    wait_done(600);
    tick();
    chk("post_flush_grant", pipe_grant, 1);

    // Two dirty lines in walk order.
    pwrite(15, 7, 1);
    pwrite(3, 2, 1);
    pread("pre_dirty_3_2", 3, 2, 1);
    start_flush();
    wait_done(800);
    tick();
    pread("clean_3_2", 3, 2, 0);
    pread("clean_15_7", 15, 7, 0);

    // Writeback stalled for 10 cycles on (0,0).
    pwrite(0, 0, 1);
    ready_force = 1'b1; ready_val = 1'b0;
    start_flush();
    wait_wb_valid(50);
    chk("stall_set", wb.wb_set, 0);
    chk("stall_way", wb.wb_way, 0);
    repeat (10) tick();
    chk("stall_still_valid", wb.wb_valid, 1);
    ready_val = 1'b1;
    wait_done(800);
    tick();

    // Pipeline write in the flush-start cycle lands; writes during the walk do not.
    ready_force = 1'b0;
    pipe_addrw = AW'(7); pipe_way = 3'd4; pipe_set1 = 1'b1; flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    pipe_addrw = AW'(9); pipe_way = 3'd1;
    repeat (4) tick();
    pipe_set1 = 1'b0;
    wait_done(1500);
    tick();
    check_clean("clean_after_ignored_writes");

    // Random dirty patterns with random writeback stalls.
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < NS; s++)
        for (int w = 0; w < NW; w++) pwrite(s, w, $urandom_range(0, 3) == 0);
      start_flush();
      wait_done(3000);
      tick();
      check_clean("clean_after_random");
    end

    // Reset while writeback of (5,1) is pending.
    ready_force = 1'b1; ready_val = 1'b0;
    pwrite(5, 1, 1);
    start_flush();
    wait_wb_valid(800);
    chk("rst_wb_set", wb.wb_set, 5);
    chk("rst_wb_way", wb.wb_way, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_grant", pipe_grant, 1);
    chk("midrst_wb_valid", wb.wb_valid, 0);
    chk("midrst_busy", flush_busy, 0);
    ready_val = 1'b1;
    begin
      int d0;
      d0 = done_cnt;
      repeat (300) tick();
      chk("midrst_no_done", done_cnt - d0, 0);
    end
    pread("midrst_dirty_kept", 5, 1, 1);

    // Four-way instance, every entry dirty: only ways 0..3 written back.
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++) pwrite(s, w, 1);
    flush_req4 = 1'b1;
    tick();
    flush_req4 = 1'b0;
    for (int i = 0; i < 2000 && done4_cnt == 0; i++) tick();
    chk("w4_done_seen", done4_cnt, 1);
    chk("w4_handshakes", k4, NS * NW4);
    begin
      int lo, hi;
      lo = 0; hi = 0;
      for (int s = 0; s < NS; s++)
        for (int w = 0; w < NW; w++)
          if (w < NW4) lo += int'(tbl4[s][w]); else hi += int'(tbl4[s][w]);
      chk("w4_low_ways_clean", lo, 0);
      chk("w4_high_ways_dirty", hi, NS * (NW - NW4));
    end
`ifdef L2_FLUSH_WBCNT_EN
    chk("w4_wb_cnt", flush_wb_cnt4, NS * NW4);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
